// File: rtl/reaction_ctrl.sv
// Reaction-time tester control: synchronises the buttons, waits a random delay,
// then sequences clear/enable pulses into the downstream 3-digit BCD ms counter.
module reaction_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_btn,
  input  logic react_btn,
  output logic count_clear,
  output logic count_enable,
  output logic led,
  output logic early,
  output logic timeout,
  output logic done
);
  localparam int         PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int         DW     = $clog2(MIN_DELAY_MS + 2048 + 1);
  localparam logic [9:0] MS_MAX = 10'd999;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TIMING, S_DONE, S_EARLY} state_t;

  state_t        state_q, state_d;
  logic [2:0]    start_sync_q, start_sync_d;
  logic [2:0]    react_sync_q, react_sync_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [9:0]    ms_q, ms_d;
  logic          clear_q, clear_d, enable_q, enable_d, led_q, led_d;
  logic          early_q, early_d, timeout_q, timeout_d, done_q, done_d;
  logic          start_e, react_e, tick;

  always_comb begin
    start_sync_d = {start_sync_q[1:0], start_btn};
    react_sync_d = {react_sync_q[1:0], react_btn};
    start_e      = start_sync_q[1] & ~start_sync_q[2];
    react_e      = react_sync_q[1] & ~react_sync_q[2];
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    tick         = (presc_q == PW'(TICK_DIV - 1));
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    dly_d     = dly_q;
    ms_d      = ms_q;
    clear_d   = 1'b0;
    enable_d  = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_DONE, S_EARLY: begin
        if (start_e) begin
          state_d   = S_WAIT;
          clear_d   = 1'b1;
          dly_d     = DW'(MIN_DELAY_MS) + DW'(lfsr_q[10:0]);
          ms_d      = '0;
          presc_d   = '0;
          timeout_d = 1'b0;
        end
      end
      S_WAIT: begin
        // A press always wins, even against the final delay tick.
        if (react_e) begin
          state_d = S_EARLY;
        end else if (tick) begin
          dly_d = dly_q - DW'(1);
          if (dly_q <= DW'(1)) begin
            state_d = S_TIMING;
            presc_d = '0;
          end
        end
      end
      S_TIMING: begin
        if (react_e) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (tick) begin
          if (ms_q < MS_MAX) begin
            enable_d = 1'b1;
            ms_d     = ms_q + 10'd1;
          end else begin
            // Stop at 999 so the BCD counter never wraps to 000.
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    led_d   = (state_d == S_TIMING);
    early_d = (state_d == S_EARLY);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      start_sync_q <= '0;
      react_sync_q <= '0;
      lfsr_q       <= 16'hACE1;
      presc_q      <= '0;
      dly_q        <= '0;
      ms_q         <= '0;
      clear_q      <= 1'b0;
      enable_q     <= 1'b0;
      led_q        <= 1'b0;
      early_q      <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_sync_q <= start_sync_d;
      react_sync_q <= react_sync_d;
      lfsr_q       <= lfsr_d;
      presc_q      <= presc_d;
      dly_q        <= dly_d;
      ms_q         <= ms_d;
      clear_q      <= clear_d;
      enable_q     <= enable_d;
      led_q        <= led_d;
      early_q      <= early_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
    end
  end

  assign count_clear  = clear_q;
  assign count_enable = enable_q;
  assign led          = led_q;
  assign early        = early_q;
  assign timeout      = timeout_q;
  assign done         = done_q;
endmodule
